lockpick_engine: RTL and testbench

LOCKPICK_ENGINE -- requirements
Module: lockpick_engine

---
 rtl/lockpick_engine.sv | 175 +++++++++++++++++
 tb/tb_lockpick_engine.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lockpick_engine.sv
// Key-guessing challenge engine: loads two key words, hashes their XOR and compares the
// result against TARGET, streaming a verdict message and enforcing a lockout after misses.
module lockpick_engine #(
  parameter int unsigned KEY_BYTES    = 32,
  parameter int unsigned ROUNDS       = 3,
  parameter int unsigned MAX_ATTEMPTS = 3,
  parameter int unsigned COOLDOWN     = 16,
  parameter logic [8*KEY_BYTES-1:0] TARGET = (8*KEY_BYTES)'(
    256'hCAFEBABE12345678DEADBEEFFEEDFACEC001D00DBADC0DE5BAADF00D0BADBEEF)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [1:0] status,
  output logic [2:0] attempts,
  output logic       busy
);

  localparam int unsigned W  = 8 * KEY_BYTES;
  localparam int unsigned CW = $clog2(KEY_BYTES);
  localparam logic [W-1:0] C = {(KEY_BYTES / 8){64'h9E3779B97F4A7C15}};

  localparam logic [1:0] StatusIdle = 2'b00;
  localparam logic [1:0] StatusErr  = 2'b01;
  localparam logic [1:0] StatusWin  = 2'b10;
  localparam logic [1:0] StatusLock = 2'b11;

  typedef enum logic [2:0] {
    StIdle, StLoadA, StLoadB, StHash, StCompare, StOutput, StCooldown
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      rnd_q, rnd_d;
  logic [7:0]      cd_q, cd_d;
  logic [2:0]      att_q, att_d, att_inc;
  logic [1:0]      status_q, status_d;
  logic [W-1:0]    key_a_q, s_q, s_round;
  logic [31:0]     msg_word;
  logic            in_xfer, out_xfer, last_byte, match;

  assign in_ready  = (state_q == StLoadA) || (state_q == StLoadB);
  assign out_valid = (state_q == StOutput);
  assign busy      = (state_q != StIdle);
  assign status    = status_q;
  assign attempts  = att_q;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign last_byte = (cnt_q == CW'(KEY_BYTES - 1));
  assign match     = (s_q == TARGET);
  assign att_inc   = (att_q < 3'(MAX_ATTEMPTS)) ? att_q + 3'd1 : att_q;
  assign s_round   = {s_q[W-14:0], s_q[W-1:W-13]} ^ (s_q + C);

  always_comb begin
    msg_word = 32'hBAD0BAD0;
    unique case (status_q)
      StatusWin:  msg_word = 32'hFACEFACE;
      StatusLock: msg_word = 32'hDEADDEAD;
      default:    msg_word = 32'hBAD0BAD0;
    endcase
    // The message repeats the 32-bit word, so byte j is word byte j mod 4.
    out_data = out_valid ? msg_word[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rnd_d    = rnd_q;
    cd_d     = cd_q;
    att_d    = att_q;
    status_d = status_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StLoadA;
          cnt_d    = '0;
          att_d    = 3'd0;
          status_d = StatusIdle;
        end
      end
      StLoadA, StLoadB: begin
        if (in_xfer) begin
          if (last_byte) begin
            state_d = (state_q == StLoadA) ? StLoadB : StHash;
            cnt_d   = '0;
            rnd_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      StHash: begin
        if (rnd_q == 4'(ROUNDS - 1)) begin
          state_d = StCompare;
          rnd_d   = 4'd0;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      StCompare: begin
        state_d = StOutput;
        cnt_d   = '0;
        if (match) begin
          status_d = StatusWin;
        end else begin
          att_d    = att_inc;
          status_d = (att_inc == 3'(MAX_ATTEMPTS)) ? StatusLock : StatusErr;
        end
      end
      StOutput: begin
        if (out_xfer) begin
          if (last_byte) begin
            cnt_d = '0;
            cd_d  = 8'd0;
            unique case (status_q)
              StatusWin:  state_d = StIdle;
              StatusLock: state_d = StCooldown;
              default:    state_d = StLoadA;
            endcase
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      StCooldown: begin
        if (cd_q == 8'(COOLDOWN - 1)) begin
          state_d = StIdle;
          cd_d    = 8'd0;
        end else begin
          cd_d = cd_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rnd_q    <= 4'd0;
      cd_q     <= 8'd0;
      att_q    <= 3'd0;
      status_q <= StatusIdle;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rnd_q    <= rnd_d;
      cd_q     <= cd_d;
      att_q    <= att_d;
      status_q <= status_d;
    end
  end

  // S is assembled byte-wise as key_a ^ key_b during LOAD_B, so it is complete on HASH entry.
  always_ff @(posedge clk) begin
    if (in_xfer && state_q == StLoadA) begin
      key_a_q[{cnt_q, 3'b000} +: 8] <= in_data;
    end
    if (in_xfer && state_q == StLoadB) begin
      s_q[{cnt_q, 3'b000} +: 8] <= key_a_q[{cnt_q, 3'b000} +: 8] ^ in_data;
    end
    if (state_q == StHash) begin
      s_q <= s_round;
    end
  end

endmodule

// File: tb/tb_lockpick_engine.sv
// Bench for lockpick_engine: three instances (8/16/32-byte keys) driven one at a time against
// a game-level reference model and an output-byte scoreboard.
module tb_lockpick_engine;

  function automatic logic [255:0] hash_ref(input logic [255:0] s0, input int kb,
                                            input int rounds);
    logic [255:0] s, c, mask;
    int w;
    w    = 8 * kb;
    mask = (kb == 32) ? {256{1'b1}} : ((256'd1 << w) - 256'd1);
    c    = '0;
    for (int i = 0; i < kb / 8; i++) c = c | (256'(64'h9E3779B97F4A7C15) << (64 * i));
    s = s0 & mask;
    for (int r = 0; r < rounds; r++) s = (((s << 13) | (s >> (w - 13))) ^ (s + c)) & mask;
    return s;
  endfunction

  localparam logic [255:0] P32 =
    256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
  localparam logic [63:0]  T8  = 64'h9E3779B97F4A7C15;
  localparam logic [127:0] T16 = 128'(hash_ref(256'd0, 16, 3));
  localparam logic [255:0] T32 = hash_ref(P32, 32, 3);

  logic       clk, rst;
  logic       start [3];
  logic       in_valid [3];
  logic [7:0] in_data [3];
  logic       out_ready [3];
  logic       in_ready_w [3];
  logic       out_valid_w [3];
  logic [7:0] out_data_w [3];
  logic [1:0] status_w [3];
  logic [2:0] attempts_w [3];
  logic       busy_w [3];

  int         checks = 0;
  int         errors = 0;
  int         act = 0;
  int         m_att = 0;
  logic [7:0] exp_q[$];

  lockpick_engine #(.KEY_BYTES(8), .ROUNDS(1), .MAX_ATTEMPTS(3), .COOLDOWN(4), .TARGET(T8))
  u_dut0 (.clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready_w[0]), .in_data(in_data[0]), .out_valid(out_valid_w[0]),
    .out_ready(out_ready[0]), .out_data(out_data_w[0]), .status(status_w[0]),
    .attempts(attempts_w[0]), .busy(busy_w[0]));

  lockpick_engine #(.KEY_BYTES(16), .ROUNDS(3), .MAX_ATTEMPTS(3), .COOLDOWN(4), .TARGET(T16))
  u_dut1 (.clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready_w[1]), .in_data(in_data[1]), .out_valid(out_valid_w[1]),
    .out_ready(out_ready[1]), .out_data(out_data_w[1]), .status(status_w[1]),
    .attempts(attempts_w[1]), .busy(busy_w[1]));

  lockpick_engine #(.KEY_BYTES(32), .ROUNDS(3), .MAX_ATTEMPTS(3), .COOLDOWN(4), .TARGET(T32))
  u_dut2 (.clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready_w[2]), .in_data(in_data[2]), .out_valid(out_valid_w[2]),
    .out_ready(out_ready[2]), .out_data(out_data_w[2]), .status(status_w[2]),
    .attempts(attempts_w[2]), .busy(busy_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int kb_of(input int d);
    return (d == 0) ? 8 : (d == 1) ? 16 : 32;
  endfunction

  function automatic int rounds_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [255:0] tgt_of(input int d);
    return (d == 0) ? 256'(T8) : (d == 1) ? 256'(T16) : T32;
  endfunction

  function automatic logic [255:0] rand_key(input int kb);
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    if (kb < 32) k = k & ((256'd1 << (8 * kb)) - 256'd1);
    return k;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Game-level reference: hash the XOR, decide the verdict, queue the expected message.
  task automatic model_game(input int d, input logic [255:0] a, input logic [255:0] b,
                            output logic [1:0] st);
    logic [255:0] s;
    logic [31:0]  w;
    s = hash_ref(a ^ b, kb_of(d), rounds_of(d));
    if (s == tgt_of(d)) begin
      st = 2'b10;
      w  = 32'hFACEFACE;
    end else begin
      if (m_att < 3) m_att++;
      st = (m_att == 3) ? 2'b11 : 2'b01;
      w  = (m_att == 3) ? 32'hDEADDEAD : 32'hBAD0BAD0;
    end
    for (int j = 0; j < kb_of(d); j++) exp_q.push_back(w[8*(j%4) +: 8]);
  endtask

  task automatic chk_reset(input int d, input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready_w[d]), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid_w[d]), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data_w[d]), 64'd0);
    chk({tag, "_busy"}, 64'(busy_w[d]), 64'd0);
    chk({tag, "_status"}, 64'(status_w[d]), 64'd0);
    chk({tag, "_attempts"}, 64'(attempts_w[d]), 64'd0);
  endtask

  task automatic do_reset(input int d);
    rst = 1'b0;
    #1;
    chk_reset(d, "rst_now");
    tick();
    chk_reset(d, "rst_next");
    exp_q.delete();
    m_att = 0;
    out_ready[d] = 1'b0;
    in_valid[d]  = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic start_game(input int d);
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    m_att = 0;
    chk("start_in_ready", 64'(in_ready_w[d]), 64'd1);
  endtask

  task automatic send_key(input int d, input logic [255:0] key, input bit rnd);
    for (int k = 0; k < kb_of(d); k++) begin
      int  budget = 0;
      bit  done = 0;
      in_data[d] = key[8*k +: 8];
      while (!done) begin
        in_valid[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (in_valid[d] && in_ready_w[d]) done = 1;
        tick();
        budget++;
        if (!done && budget > 100) begin
          chk("load_timeout", 64'(budget), 64'd0);
          done = 1;
        end
      end
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic recv(input int d, input bit stall);
    int n = 0;
    out_ready[d] = 1'b1;
    while (exp_q.size() > 0 && n < 200) begin
      if (stall && n == 3) begin
        out_ready[d] = 1'b0;
        repeat (5) tick();
        out_ready[d] = 1'b1;
      end
      tick();
      n++;
    end
    out_ready[d] = 1'b0;
    chk("bytes_left", 64'(exp_q.size()), 64'd0);
  endtask

  // rst_at: 0 play through, 1 reset in HASH, 2 reset mid-message.
  task automatic guess(input int d, input logic [255:0] a, input logic [255:0] b,
                       input bit rnd, input bit stall, input int rst_at);
    logic [1:0] st;
    int n;
    model_game(d, a, b, st);
    send_key(d, a, rnd);
    send_key(d, b, rnd);
    if (rst_at == 1) begin
      do_reset(d);
      return;
    end
    n = 1;
    while (!out_valid_w[d] && n < 64) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'(rounds_of(d) + 2));
    chk("status", 64'(status_w[d]), 64'(st));
    chk("attempts", 64'(attempts_w[d]), 64'(m_att));
    chk("first_byte", 64'(out_data_w[d]),
        (st == 2'b10) ? 64'hCE : (st == 2'b01) ? 64'hD0 : 64'hAD);
    if (rst_at == 2) begin
      out_ready[d] = 1'b1;
      repeat (2) tick();
      out_ready[d] = 1'b0;
      do_reset(d);
      return;
    end
    recv(d, stall);
  endtask

  logic [7:0] prev_data;
  bit         prev_stall = 0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) chk("stall_hold", 64'(out_data_w[act]), 64'(prev_data));
      chk("ready_valid_excl", 64'(out_valid_w[act] && in_ready_w[act]), 64'd0);
      if (out_valid_w[act] && out_ready[act]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got %0h expected none", out_data_w[act]);
        end else begin
          chk("out_byte", 64'(out_data_w[act]), 64'(exp_q.pop_front()));
        end
      end
      prev_stall = out_valid_w[act] && !out_ready[act];
      prev_data  = out_data_w[act];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] k;
    int n;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0;
      in_valid[d] = 1'b0;
      in_data[d] = 8'h00;
      out_ready[d] = 1'b0;
    end
    repeat (3) tick();
    for (int d = 0; d < 3; d++) chk_reset(d, "por");
    rst = 1'b1;
    tick();

    chk("pin_hash0", hash_ref(256'd0, 8, 1)[63:0], 64'h9E3779B97F4A7C15);
    chk("pin_hash1", hash_ref(256'd1, 8, 1)[63:0], 64'h9E3779B97F4A5C16);

    act = 0;
    // Win with equal keys.
    start_game(0);
    k = rand_key(8);
    guess(0, k, k, 0, 0, 0);
    chk("win_idle_busy", 64'(busy_w[0]), 64'd0);
    chk("win_status_hold", 64'(status_w[0]), 64'd2);

    // Error, then two more misses under backpressure into lockout.
    start_game(0);
    guess(0, 256'd0, 256'd1, 0, 0, 0);
    chk("err_back_to_load", 64'(in_ready_w[0]), 64'd1);
    k = rand_key(8);
    guess(0, k, k ^ 256'd1, 1, 1, 0);
    chk("err2_attempts", 64'(attempts_w[0]), 64'd2);
    k = rand_key(8);
    guess(0, k, k ^ 256'd2, 1, 1, 0);
    start[0] = 1'b1;
    n = 0;
    while (busy_w[0] && n < 50) begin
      chk("cool_status", 64'(status_w[0]), 64'd3);
      chk("cool_no_ready", 64'(in_ready_w[0]), 64'd0);
      tick();
      n++;
    end
    start[0] = 1'b0;
    chk("cooldown_len", 64'(n), 64'd4);
    chk("lock_status_idle", 64'(status_w[0]), 64'd3);
    chk("lock_attempts_idle", 64'(attempts_w[0]), 64'd3);
    tick();
    chk("lock_stays_idle", 64'(busy_w[0]), 64'd0);

    // Reset mid-HASH and mid-OUTPUT, each followed by a clean winning game.
    start_game(0);
    k = rand_key(8);
    guess(0, k, rand_key(8), 0, 0, 1);
    start_game(0);
    k = rand_key(8);
    guess(0, k, k, 1, 0, 0);
    chk("post_rst1_idle", 64'(busy_w[0]), 64'd0);
    start_game(0);
    guess(0, 256'd0, 256'd1, 0, 0, 2);
    start_game(0);
    k = rand_key(8);
    guess(0, k, k, 0, 1, 0);
    chk("post_rst2_idle", 64'(busy_w[0]), 64'd0);

    // Wider keys with three rounds.
    act = 1;
    start_game(1);
    k = rand_key(16);
    guess(1, k, k, 1, 1, 0);
    chk("kb16_win_idle", 64'(busy_w[1]), 64'd0);
    start_game(1);
    k = rand_key(16);
    guess(1, k, rand_key(16), 1, 0, 0);

    act = 2;
    start_game(2);
    k = rand_key(32);
    guess(2, k, k ^ P32, 1, 1, 0);
    chk("kb32_win_idle", 64'(busy_w[2]), 64'd0);
    start_game(2);
    k = rand_key(32);
    guess(2, k, k ^ 256'd5, 0, 0, 0);
    chk("kb32_err_load", 64'(in_ready_w[2]), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
